// File: rtl/arp_pkg.sv
// Shared ARP decode types and constants: FSM state enum, fixed header
// values, opcodes and the 28-byte IPv4-over-Ethernet ARP length.
package arp_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StHdr,
        StOper,
        StSha,
        StSpa,
        StTha,
        StTpa,
        StWaitEnd,
        StCheck
    } arp_state_e;

    localparam logic [15:0] ArpHtype     = 16'h0001;
    localparam logic [15:0] ArpPtype     = 16'h0800;
    localparam logic [7:0]  ArpHlen      = 8'd6;
    localparam logic [7:0]  ArpPlen      = 8'd4;
    localparam logic [15:0] ArpOpRequest = 16'h0001;
    localparam logic [15:0] ArpOpReply   = 16'h0002;
    localparam int unsigned ArpLen       = 28;
    localparam logic [4:0]  ArpLastByte  = 5'(ArpLen - 1);

    // Expected value of fixed header byte 0..5.
    function automatic logic [7:0] hdr_byte(input logic [4:0] idx);
        logic [7:0] b;
        case (idx)
            5'd0:    b = ArpHtype[15:8];
            5'd1:    b = ArpHtype[7:0];
            5'd2:    b = ArpPtype[15:8];
            5'd3:    b = ArpPtype[7:0];
            5'd4:    b = ArpHlen;
            5'd5:    b = ArpPlen;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Field state that will consume byte n.
    function automatic arp_state_e field_state(input logic [4:0] n);
        arp_state_e s;
        if (n < 5'd6)       s = StHdr;
        else if (n < 5'd8)  s = StOper;
        else if (n < 5'd14) s = StSha;
        else if (n < 5'd18) s = StSpa;
        else if (n < 5'd24) s = StTha;
        else if (n < 5'd28) s = StTpa;
        else                s = StWaitEnd;
        return s;
    endfunction

endpackage

// File: rtl/arp_decode.sv
// ARP packet decoder: validates header/opcode/target IP and reports accept or drop
// after frame end. Define ARP_REPLY_EN to also accept opcode 2 (reported via is_reply).
module arp_decode
    import arp_pkg::*;
#(
    parameter logic [31:0] IP_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rxd,
    input  logic        rx_dv,
    input  logic        arp_decode_valid,
    input  logic        crc_err,
    output logic        arp_valid,
    output logic        is_reply,
    output logic [47:0] sha,
    output logic [31:0] spa,
    output logic        arp_drop
);

    arp_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        mismatch_q, mismatch_d;
    logic        reply_q, reply_d;
    logic [47:0] sha_sr_q, sha_sr_d;
    logic [31:0] spa_sr_q, spa_sr_d;
    logic [23:0] tpa_sr_q, tpa_sr_d;
    logic [47:0] sha_q, sha_d;
    logic [31:0] spa_q, spa_d;
    logic        is_reply_q, is_reply_d;
    logic        arp_valid_q, arp_valid_d;
    logic        arp_drop_q, arp_drop_d;
    logic        bad;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mismatch_d  = mismatch_q;
        reply_d     = reply_q;
        sha_sr_d    = sha_sr_q;
        spa_sr_d    = spa_sr_q;
        tpa_sr_d    = tpa_sr_q;
        sha_d       = sha_q;
        spa_d       = spa_q;
        is_reply_d  = is_reply_q;
        arp_valid_d = 1'b0;
        arp_drop_d  = 1'b0;
        bad         = 1'b0;

        case (state_q)
            StIdle: begin
                if (arp_decode_valid) begin
                    cnt_d      = 5'd1;
                    mismatch_d = (rxd != hdr_byte(5'd0));
                    reply_d    = 1'b0;
                    state_d    = StHdr;
                end
            end
            StHdr, StOper, StSha, StSpa, StTha, StTpa: begin
                if (!(rx_dv && arp_decode_valid)) begin
                    // Truncated packet: drop immediately.
                    state_d    = StIdle;
                    cnt_d      = 5'd0;
                    mismatch_d = 1'b0;
                    arp_drop_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 5'd1;
                    state_d = field_state(cnt_q + 5'd1);
                    case (state_q)
                        StHdr: bad = (rxd != hdr_byte(cnt_q));
                        StOper: begin
                            if (cnt_q == 5'd6) begin
                                bad = (rxd != ArpOpRequest[15:8]);
                            end else begin
`ifdef ARP_REPLY_EN
                                reply_d = (rxd == ArpOpReply[7:0]);
                                bad     = (rxd != ArpOpRequest[7:0]) &&
                                          (rxd != ArpOpReply[7:0]);
`else
                                bad = (rxd != ArpOpRequest[7:0]);
`endif
                            end
                        end
                        StSha: if (!mismatch_q) sha_sr_d = {sha_sr_q[39:0], rxd};
                        StSpa: if (!mismatch_q) spa_sr_d = {spa_sr_q[23:0], rxd};
                        StTpa: begin
                            tpa_sr_d = {tpa_sr_q[15:0], rxd};
                            if (cnt_q == ArpLastByte) bad = ({tpa_sr_q, rxd} != IP_ADDR);
                        end
                        default: ;
                    endcase
                    if (bad) mismatch_d = 1'b1;
                end
            end
            StWaitEnd: begin
                if (!rx_dv) state_d = StCheck;
            end
            StCheck: begin
                state_d    = StIdle;
                cnt_d      = 5'd0;
                mismatch_d = 1'b0;
                if (!crc_err && !mismatch_q) begin
                    arp_valid_d = 1'b1;
                    sha_d       = sha_sr_q;
                    spa_d       = spa_sr_q;
                    is_reply_d  = reply_q;
                end else begin
                    arp_drop_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 5'd0;
            mismatch_q  <= 1'b0;
            reply_q     <= 1'b0;
            sha_sr_q    <= 48'h0;
            spa_sr_q    <= 32'h0;
            tpa_sr_q    <= 24'h0;
            sha_q       <= 48'h0;
            spa_q       <= 32'h0;
            is_reply_q  <= 1'b0;
            arp_valid_q <= 1'b0;
            arp_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mismatch_q  <= mismatch_d;
            reply_q     <= reply_d;
            sha_sr_q    <= sha_sr_d;
            spa_sr_q    <= spa_sr_d;
            tpa_sr_q    <= tpa_sr_d;
            sha_q       <= sha_d;
            spa_q       <= spa_d;
            is_reply_q  <= is_reply_d;
            arp_valid_q <= arp_valid_d;
            arp_drop_q  <= arp_drop_d;
        end
    end

    assign arp_valid = arp_valid_q;
    assign arp_drop  = arp_drop_q;
    assign sha       = sha_q;
    assign spa       = spa_q;
    assign is_reply  = is_reply_q;

endmodule
